// File: rtl/seq_subtractor_32_bit_if.sv
// Request/response bundle for the sequential subtractor: operands and start
// from the controller, busy/done and the result with its condition flags back.
interface seq_subtractor_32_bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             borrowIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrow;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output start, input1, input2, borrowIn,
        input  busy, done, difference, borrow, zero, negative, overflow
    );

    modport slave (
        input  start, input1, input2, borrowIn,
        output busy, done, difference, borrow, zero, negative, overflow
    );
endinterface

// File: rtl/seq_subtractor_32_bit.sv
// Multi-cycle subtractor: one CHUNK-bit slice per clock, LSB slice first,
// rippling the borrow; the result and flags update only on the final slice.
module seq_subtractor_32_bit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    seq_subtractor_32_bit_if.slave    bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("WIDTH must be an integer multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic               bin_q, bin_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    // Operands shift right each RUN cycle so the active slice is always the
    // low CHUNK bits; finished slices enter the partial result from the top.
    logic [CHUNK:0]     slice_w;
    logic [WIDTH-1:0]   full_w;

    assign slice_w = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                   - {{CHUNK{1'b0}}, bin_q};

    generate
        if (NCHUNK == 1) begin : g_one_slice
            assign full_w = slice_w[CHUNK-1:0];
        end else begin : g_multi_slice
            assign full_w = {slice_w[CHUNK-1:0], part_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bin_d    = bin_q;
        idx_d    = idx_q;
        part_d   = part_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.input1;
                    b_d     = bus.input2;
                    a_msb_d = bus.input1[WIDTH-1];
                    b_msb_d = bus.input2[WIDTH-1];
                    bin_d   = bus.borrowIn;
                    idx_d   = '0;
                    part_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                part_d = full_w;
                a_d    = a_q >> CHUNK;
                b_d    = b_q >> CHUNK;
                bin_d  = slice_w[CHUNK];
                if (idx_q == LAST_IDX) begin
                    // Flags come from the complete result, never a single slice.
                    diff_d   = full_w;
                    borrow_d = slice_w[CHUNK];
                    zero_d   = (full_w == '0);
                    neg_d    = full_w[WIDTH-1];
                    ovf_d    = (a_msb_q != b_msb_q) && (full_w[WIDTH-1] != a_msb_q);
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bin_q    <= 1'b0;
            idx_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bin_q    <= bin_d;
            idx_q    <= idx_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.difference = diff_q;
    assign bus.borrow     = borrow_q;
    assign bus.zero       = zero_q;
    assign bus.negative   = neg_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_seq_subtractor_32_bit.sv
// Directed-vector bench: the driver pushes hand-computed results into a
// scoreboard queue, and a monitor pops and checks one entry per done pulse.
module tb_seq_subtractor_32_bit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_subtractor_32_bit_if #(.WIDTH(32)) bus ();

    seq_subtractor_32_bit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] d;
        logic        b;
        logic        z;
        logic        n;
        logic        v;
        int          c0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_diff"},    bus.difference, mon_e.d);
                chk({mon_e.name, "_borrow"},  {31'b0, bus.borrow},   {31'b0, mon_e.b});
                chk({mon_e.name, "_zero"},    {31'b0, bus.zero},     {31'b0, mon_e.z});
                chk({mon_e.name, "_neg"},     {31'b0, bus.negative}, {31'b0, mon_e.n});
                chk({mon_e.name, "_ovf"},     {31'b0, bus.overflow}, {31'b0, mon_e.v});
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.c0), 32'd4);
                $display("txn %s: diff=%h borrow=%b zero=%b neg=%b ovf=%b latency=%0d",
                         mon_e.name, bus.difference, bus.borrow, bus.zero,
                         bus.negative, bus.overflow, cyc - mon_e.c0);
            end
        end
    end

    task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic bi, input logic [31:0] d, input logic bo,
                            input logic z, input logic n, input logic v);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.input1   = a;
        bus.input2   = b;
        bus.borrowIn = bi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.name = name;
        e.d = d; e.b = bo; e.z = z; e.n = n; e.v = v;
        e.c0 = cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_idle(input string name, input logic [31:0] d);
        int k = 0;
        while ((sbq.size() != 0 || bus.busy !== 1'b0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no completion expected done within 40 cycles", name);
            sbq.delete();
        end
        @(negedge clk);
        chk({name, "_hold"}, bus.difference, d);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic [31:0] d, input logic bo,
                          input logic z, input logic n, input logic v);
        start_op(name, a, b, bi, d, bo, z, n, v);
        wait_idle(name, d);
    endtask

    initial begin
        int nb;
        int d0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.input1   = '0;
        bus.input2   = '0;
        bus.borrowIn = 1'b0;
        #12;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_diff", bus.difference, 32'd0);
        chk("rst_flags", {28'b0, bus.borrow, bus.zero, bus.negative, bus.overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First operation also measures how long busy stays high.
        start_op("sub_5_3", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        nb = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy === 1'b1) nb++;
        end
        chk("busy_cycles", 32'(nb), 32'd5);
        wait_idle("sub_5_3", 32'h2);

        run_op("sub_0_1",    32'h0,        32'h1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("ripple_100", 32'h100,      32'h1,        1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("ripple_1M",  32'h01000000, 32'h1,        1'b0, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("ovf_min",    32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("ovf_max",    32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1);

        // Borrow-in producing zero; a second start during RUN must be ignored.
        start_op("bin_zero", 32'h5, 32'h4, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.input1   = 32'h12345678;
        bus.input2   = 32'h1;
        bus.borrowIn = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_idle("bin_zero", 32'h0);

        run_op("bin_equal", 32'h1234, 32'h1234, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset two cycles into an operation aborts it.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.input1   = 32'hAAAAAAAA;
        bus.input2   = 32'h11111111;
        bus.borrowIn = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_diff", bus.difference, 32'd0);
        chk("abort_flags", {28'b0, bus.borrow, bus.zero, bus.negative, bus.overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));

        run_op("after_abort", 32'h10, 32'h20, 1'b0, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_subtractor_32_bit.md
Name: seq_subtractor_32_bit

Overview:
- Multi-cycle 32-bit subtractor with borrow-in/borrow-out and condition flags, built for the RISC datapath ALU.
- It is the inverse-direction companion of the 32-bit adder.
- Processes one CHUNK-bit slice per clock, least significant slice first, rippling the borrow between slices.
- Uses a start/busy/done handshake, so the datapath controller can issue SUB/compare operations and wait for completion.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits subtracted per cycle. WIDTH must be an integer multiple of CHUNK; otherwise elaboration fails.
- NCHUNK (derived), WIDTH/CHUNK, number of RUN cycles (4 at defaults).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- input1  input  WIDTH  minuend.
- input2  input  WIDTH  subtrahend.
- borrowIn  input  1  borrow into the least significant bit.
- busy  output  1  high while an operation is in progress (RUN and DONE).
- done  output  1  one-cycle pulse: result outputs are valid and newly updated.
- difference  output  WIDTH  input1 - input2 - borrowIn, mod 2^WIDTH.
- borrow  output  1  1 iff input1 < input2 + borrowIn (unsigned).
- zero  output  1  difference == 0.
- negative  output  1  difference[WIDTH-1].
- overflow  output  1  signed overflow: input1[MSB] != input2[MSB] and difference[MSB] != input1[MSB].

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Reset forces state IDLE and clears busy, done, difference, borrow, zero, negative, overflow, the internal chunk index and the operand registers to 0. Reset asserted mid-operation aborts it; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at edge E0: latch input1, input2 and borrowIn into internal registers, set index=0 and go to RUN.
  - busy=1 from E0.
- RUN:
  - At each edge, compute slice i = A[i*CHUNK +: CHUNK] - B[i*CHUNK +: CHUNK] - b. Write it to the internal partial result and update b to the slice borrow-out. Then i increments.
  - After slice NCHUNK-1 (edge E4 at defaults), go to DONE. At that same edge, load difference, borrow, zero, negative and overflow from the full partial result, and set done=1.
- DONE: done=1 and busy=1 for exactly one cycle. Next edge returns to IDLE with done=0 and busy=0.
- Latency: start sampled at E0, done high after E(NCHUNK), so 4 cycles at defaults. Minimum issue interval is NCHUNK+2 cycles.
- Result outputs change only at the completion edge. Between operations they hold their last value, including after done drops.
- start is ignored while in RUN or DONE. Input changes after E0 do not affect the operation in flight.
- Borrow must propagate across slice boundaries exactly as in a full-width subtract.
- Flags derive from the final full-width result only, never from an intermediate slice.
- borrowIn=1 with input1==input2 gives difference = all ones and borrow=1.

Test Plan:
- Reset, then start with 0x00000005 - 0x00000003, borrowIn=0 -> done pulses 4 cycles after start; difference=0x00000002, borrow=0, zero=0, negative=0, overflow=0; busy high for 5 cycles.
- 0x00000000 - 0x00000001, borrowIn=0 -> difference=0xFFFFFFFF, borrow=1, negative=1, zero=0, overflow=0.
- Slice-boundary borrow ripple: 0x00000100 - 0x00000001 -> 0x000000FF, borrow=0. Also 0x01000000 - 0x00000001 -> 0x00FFFFFF.
- Signed overflow: 0x80000000 - 0x00000001 -> 0x7FFFFFFF, overflow=1, borrow=0, negative=0. Also 0x7FFFFFFF - 0xFFFFFFFF -> 0x80000000, overflow=1, borrow=1.
- Borrow-in and zero flag: 0x00000005 - 0x00000004, borrowIn=1 -> difference=0, zero=1, borrow=0. Then re-pulse start during RUN with new operands -> ignored; the first result is unchanged.
- Assert reset 2 cycles after start -> busy=0 immediately (asynchronous); all outputs 0; no done pulse. A fresh start afterwards completes normally with a correct result.
